// File: rtl/trace_feeder.sv
// trace_feeder: replays a stored address trace into the cache core,
// one access per trace_ready / update_lru handshake, with prefetch.
module trace_feeder #(
  parameter int ADDR_W     = 32,
  parameter int TRACE_AW   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [TRACE_AW:0]   trace_len,
  output logic                tm_rd_en,
  output logic [TRACE_AW-1:0] tm_rd_addr,
  input  logic [ADDR_W-1:0]   tm_rd_data,
  output logic                trace_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                update_lru,
  output logic                busy,
  output logic                done,
  output logic [31:0]         issued_count,
  output logic                protocol_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DONE
  } state_t;

  state_t state_q, state_d;

  logic [TRACE_AW:0]   len_q, len_d;
  logic [TRACE_AW:0]   ptr_q, ptr_d;
  logic [TRACE_AW:0]   ptr_base;
  logic [ADDR_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_d [FIFO_DEPTH];
  logic [PW-1:0]       wp_q, wp_d;
  logic [PW-1:0]       rp_q, rp_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rd_vld_q, rd_vld_d;
  logic                rd_en_q, rd_en_d;
  logic [TRACE_AW-1:0] rd_addr_q, rd_addr_d;
  logic                ready_q, ready_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [31:0]         icnt_q, icnt_d;
  logic                perr_q, perr_d;

  logic go;
  logic accept;
  logic last;
  logic push;
  logic pop;
  logic active_d;

  assign go     = start
                & ((state_q == IDLE)
                |  (state_q == DONE));
  assign accept = update_lru
                & (state_q == WAIT)
                & ~ready_q;
  assign last   = accept
                & ((icnt_q + 32'd1)
                   == 32'(len_q));
  assign push   = rd_vld_q;
  assign pop    = (cnt_q != '0)
                & ((state_q == ISSUE)
                |  (accept & ~last));

  // Next state, FIFO bookkeeping and prefetch decision
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    fifo_d    = fifo_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    rd_vld_d  = rd_en_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    ready_d   = 1'b0;
    maddr_d   = maddr_q;
    busy_d    = busy_q;
    done_d    = done_q;
    icnt_d    = icnt_q;
    perr_d    = perr_q;
    ptr_base  = ptr_q;
    ptr_d     = ptr_q;
    active_d  = 1'b0;

    if (push) begin
      fifo_d[wp_q] = tm_rd_data;
      wp_d         = wp_q + PW'(1);
    end
    if (pop) begin
      maddr_d = fifo_q[rp_q];
      rp_d    = rp_q + PW'(1);
      ready_d = 1'b1;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d    = trace_len;
          icnt_d   = '0;
          perr_d   = 1'b0;
          done_d   = 1'b0;
          wp_d     = '0;
          rp_d     = '0;
          cnt_d    = '0;
          ptr_base = '0;
          if (trace_len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            busy_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (pop) state_d = WAIT;
      end
      WAIT: begin
        if (accept) begin
          icnt_d = icnt_q + 32'd1;
          if (last) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (!pop) begin
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (update_lru && !accept)
      perr_d = 1'b1;

    active_d = (state_d == ISSUE)
             | (state_d == WAIT);
    ptr_d    = ptr_base;
    if (active_d
        && (ptr_base < len_d)
        && ((cnt_d + CW'(rd_en_q))
            < CW'(FIFO_DEPTH))) begin
      rd_en_d   = 1'b1;
      rd_addr_d = ptr_base[TRACE_AW-1:0];
      ptr_d     = ptr_base
                + (TRACE_AW+1)'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      ptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo_q[i] <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      ready_q   <= 1'b0;
      maddr_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      icnt_q    <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      ptr_q     <= ptr_d;
      fifo_q    <= fifo_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      rd_vld_q  <= rd_vld_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      ready_q   <= ready_d;
      maddr_q   <= maddr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      icnt_q    <= icnt_d;
      perr_q    <= perr_d;
    end
  end

  assign tm_rd_en     = rd_en_q;
  assign tm_rd_addr   = rd_addr_q;
  assign trace_ready  = ready_q;
  assign mem_addr     = maddr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign issued_count = icnt_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_trace_feeder.sv
// tb_trace_feeder: random and directed runs of trace_feeder against
// a transaction-level model of issue timing, ordering and status.
module tb_trace_feeder;
  localparam int AW    = 32;
  localparam int TAW   = 16;
  localparam int DEPTH = 4;
  localparam int MEMN  = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [TAW:0]   trace_len = '0;
  logic           tm_rd_en;
  logic [TAW-1:0] tm_rd_addr;
  logic [AW-1:0]  tm_rd_data;
  logic           trace_ready;
  logic [AW-1:0]  mem_addr;
  logic           update_lru = 1'b0;
  logic           busy;
  logic           done;
  logic [31:0]    issued_count;
  logic           protocol_err;

  logic [AW-1:0] mem [MEMN];
  int errs = 0;
  int checks = 0;
  int tcyc = 0;

  bit m_busy, m_done, m_perr, m_out;
  int m_len, m_cnt, m_reads, m_pulses;
  int m_elig, m_start, m_first, m_last;
  int rd_cyc [MEMN];

  trace_feeder #(
    .ADDR_W(AW),
    .TRACE_AW(TAW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .trace_len(trace_len),
    .tm_rd_en(tm_rd_en),
    .tm_rd_addr(tm_rd_addr),
    .tm_rd_data(tm_rd_data),
    .trace_ready(trace_ready),
    .mem_addr(mem_addr),
    .update_lru(update_lru),
    .busy(busy),
    .done(done),
    .issued_count(issued_count),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tcyc <= tcyc + 1;

  // synchronous trace memory, one cycle read latency
  always @(posedge clk)
    tm_rd_data <= tm_rd_en ? mem[tm_rd_addr[5:0]]
                           : $urandom;

  function automatic void chk(string name,
                              longint act,
                              longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h cyc %0d",
               name, act, exp, tcyc);
    end
  endfunction

  // compare process: model expectations for this cycle, then advance
  always @(negedge clk) begin : cmp
    bit exp_rdy;
    bit acc;
    bit was_busy;
    int tgt;
    if (!rst_n) begin
      chk("rst_rd_en", tm_rd_en, 0);
      chk("rst_rd_addr", tm_rd_addr, 0);
      chk("rst_ready", trace_ready, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", issued_count, 0);
      chk("rst_perr", protocol_err, 0);
      m_busy = 0; m_done = 0; m_perr = 0;
      m_out = 0; m_len = 0; m_cnt = 0;
      m_reads = 0; m_pulses = 0; m_elig = 0;
    end else begin
      was_busy = m_busy;
      exp_rdy = 0;
      if (m_busy && !m_out && m_pulses < m_reads) begin
        tgt = rd_cyc[m_pulses] + 3;
        if (m_elig > tgt) tgt = m_elig;
        exp_rdy = (tcyc == tgt);
      end
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("issued_count", issued_count, m_cnt);
      chk("protocol_err", protocol_err, m_perr);
      chk("trace_ready", trace_ready, exp_rdy);
      if (exp_rdy)
        chk("mem_addr", mem_addr, mem[m_pulses]);
      chk("rd_en_illegal",
          tm_rd_en && (!m_busy || m_reads >= m_len), 0);
      acc = update_lru && m_busy && m_out && !exp_rdy;
      if (exp_rdy) begin
        if (m_pulses == 0) m_first = tcyc;
        m_last = tcyc;
        m_pulses++;
        m_out = 1;
      end
      if (tm_rd_en && m_busy && m_reads < m_len) begin
        chk("rd_addr", tm_rd_addr, m_reads);
        rd_cyc[m_reads] = tcyc;
        m_reads++;
      end
      chk("fifo_bound", (m_reads - m_pulses) > DEPTH, 0);
      if (update_lru && !acc) m_perr = 1;
      if (acc) begin
        m_cnt++;
        m_out = 0;
        m_elig = tcyc + 1;
        if (m_cnt == m_len) begin
          m_busy = 0;
          m_done = 1;
        end
      end
      if (start && !was_busy) begin
        m_len = int'(trace_len);
        m_cnt = 0; m_perr = 0;
        m_done = (m_len == 0);
        m_busy = (m_len != 0);
        m_reads = 0; m_pulses = 0; m_out = 0;
        m_elig = tcyc + 1;
        m_start = tcyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one run with a core that answers dmin..dmax cycles after each pulse
  task automatic run_trace(int len, int dmin, int dmax,
                           bit inj, int xs_at, int xs_len);
    int cd;
    bit fin;
    cd = 0;
    fin = 0;
    start = 1;
    trace_len = (TAW+1)'(len);
    update_lru = 0;
    tick();
    start = 0;
    for (int i = 0; i < 3000 && !fin; i++) begin
      update_lru = 0;
      start = 0;
      if (done) begin
        fin = 1;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) update_lru = 1;
        end
        if (trace_ready) begin
          cd = $urandom_range(dmax, dmin);
          if (inj) update_lru = 1;
        end
        if (i == xs_at) begin
          start = 1;
          trace_len = (TAW+1)'(xs_len);
        end
        tick();
      end
    end
    start = 0;
    update_lru = 0;
    chk("run_timeout", fin, 1);
  endtask

  initial begin
    int len;
    for (int i = 0; i < MEMN; i++) mem[i] = $urandom;
    mem[0] = 32'h1000;
    mem[1] = 32'h2000;
    mem[2] = 32'h3000;
    #2 rst_n = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();

    // empty trace, then restart from DONE
    start = 1;
    trace_len = '0;
    tick();
    start = 0;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    tick();
    run_trace(1, 2, 2, 0, -1, 0);
    chk("len1_count", issued_count, 1);
    chk("len1_done", done, 1);

    // basic three-address run
    run_trace(3, 3, 3, 0, -1, 0);
    chk("basic_first_read", rd_cyc[0] - m_start, 1);
    chk("basic_first_pulse", m_first - m_start, 4);
    chk("basic_count", issued_count, 3);
    chk("basic_last_addr", mem_addr, 32'h3000);
    chk("basic_done", done, 1);

    // back-to-back responses
    run_trace(16, 1, 1, 0, -1, 0);
    chk("b2b_span", m_last - m_first, 30);
    chk("b2b_count", issued_count, 16);

    // responses in the pulse cycle are errors
    run_trace(6, 1, 3, 1, -1, 0);
    chk("perr_set", protocol_err, 1);
    chk("perr_count", issued_count, 6);

    // start while busy is ignored
    run_trace(2, 3, 3, 0, 2, 5);
    chk("busy_start_count", issued_count, 2);
    chk("busy_start_done", done, 1);

    // reset right after a pulse
    start = 1;
    trace_len = (TAW+1)'(5);
    tick();
    start = 0;
    for (int i = 0; i < 50 && !trace_ready; i++) tick();
    chk("pre_reset_pulse", trace_ready, 1);
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
    update_lru = 1;
    tick();
    update_lru = 0;
    chk("idle_perr", protocol_err, 1);
    chk("idle_count", issued_count, 0);
    tick();
    run_trace(3, 2, 2, 0, -1, 0);
    chk("post_rst_count", issued_count, 3);
    chk("post_rst_perr", protocol_err, 0);
    chk("post_rst_addr", mem_addr, 32'h3000);

    // randomized runs
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < MEMN; i++) mem[i] = $urandom;
      len = $urandom_range(40, 1);
      run_trace(len, 1, $urandom_range(4, 1),
                1'($urandom_range(1, 0)),
                ($urandom_range(1, 0) != 0) ? 3 : -1,
                $urandom_range(9, 1));
      chk("rand_count", issued_count, len);
    end

    tick();
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/trace_feeder.md
# trace_feeder

Synthesizable trace source that replaces the file-driven stimulus on the cache simulator's trace port. Reads a stored address trace from an external synchronous trace memory and presents one address at a time to the cache core with a single-cycle `trace_ready` pulse. Waits for the core's `update_lru` completion strobe before issuing the next address, prefetching through a small FIFO so back-to-back issue is possible. Sits between the on-chip trace BRAM and the cache `main` core.

## Interface
- `ADDR_W`, 32, width of a trace address / `mem_addr`
- `TRACE_AW`, 16, trace memory address width; max trace length 2^TRACE_AW
- `FIFO_DEPTH`, 4, prefetch FIFO entries (power of two, ≥2)
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle request to run a trace; honoured only in IDLE or DONE
- `trace_len` in TRACE_AW+1: number of addresses to issue; sampled with `start`
- `tm_rd_en` out 1: trace memory read enable
- `tm_rd_addr` out TRACE_AW: trace memory word address
- `tm_rd_data` in ADDR_W: read data, valid exactly 1 cycle after `tm_rd_en`
- `trace_ready` out 1: one-cycle pulse, `mem_addr` valid
- `mem_addr` out ADDR_W: address presented to the cache core
- `update_lru` in 1: cache core finished the current access
- `busy` out 1: run in progress
- `done` out 1: run complete, held until next accepted `start` or reset
- `issued_count` out 32: accesses completed (update_lru accepted) in current run
- `protocol_err` out 1: sticky; `update_lru` seen when no access outstanding

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE/DONE + `start`: latch `trace_len`, clear `issued_count`, fetch pointer, FIFO, `protocol_err`; `done`←0. If `trace_len`==0 go DONE (`done`=1 next cycle, no reads); else go ISSUE, `busy`=1.
- Prefetcher (active in ISSUE/WAIT): assert `tm_rd_en` with `tm_rd_addr`=fetch pointer when pointer < len and (FIFO count + in-flight read) < FIFO_DEPTH; pointer increments per read; addresses strictly 0..len-1, each read exactly once. Returned data pushed into FIFO the cycle it is valid.
- ISSUE: when FIFO non-empty, pop head into `mem_addr` register, pulse `trace_ready` next cycle, go WAIT.
- WAIT: `trace_ready`=0, `mem_addr` held. On `update_lru`=1: `issued_count`+1; if new count == len go DONE (`busy`=0, `done`=1), else ISSUE.
- `update_lru` in any state other than WAIT (incl. the cycle `trace_ready` is high) is ignored for counting and sets `protocol_err`.
- `start` while `busy` ignored; no abort other than reset.
- `issued_count` 32-bit, never wraps within a run (len ≤ 2^16).

## Timing
- Reset values: `tm_rd_en`=0, `tm_rd_addr`=0, `trace_ready`=0, `mem_addr`=0, `busy`=0, `done`=0, `issued_count`=0, `protocol_err`=0; state IDLE, FIFO empty.
- `start` sampled at cycle 0 → first `tm_rd_en` cycle 1 (addr 0) → data cycle 2 → FIFO non-empty cycle 3 → first `trace_ready` cycle 4.
- All outputs registered. `update_lru` high in cycle n with FIFO non-empty → next `trace_ready` in cycle n+1 (min spacing 2 cycles between pulses).
- FIFO empty at `update_lru` (memory stall): `trace_ready` in cycle after FIFO becomes non-empty.
- `done` rises the cycle after the final `update_lru`; `busy` falls same cycle.
- Reset asserted mid-run: all state and outputs to reset values immediately; in-flight read data discarded.
- FIFO full: no read issued; never overflows, never reads past len-1.

## Test plan
- Reset mid-WAIT: assert `rst_n`=0 with `trace_ready` just pulsed -> all outputs 0 immediately; after release, `start` with len 3 runs cleanly from address 0.
- Basic run: memory = {0x1000,0x2000,0x3000}, len=3, core responds `update_lru` 3 cycles after each pulse -> `mem_addr` sequence 0x1000,0x2000,0x3000, first pulse at cycle 4, `issued_count`=3, `done`=1, `tm_rd_addr` never exceeds 2.
- Back-to-back: len=16, `update_lru` in cycle after each pulse -> pulses every 2 cycles, FIFO never overflows, 16 distinct reads.
- len=0 and restart: `start` len=0 -> `done`=1 at cycle 1, no `tm_rd_en`, no pulse; then `start` len=1 from DONE -> one pulse, `done` re-asserts.
- Protocol error: `update_lru` in IDLE and in the `trace_ready` cycle -> `protocol_err`=1, `issued_count` unchanged, run still completes on legal responses.
- `start` ignored while busy: second `start` with len=5 during len=2 run -> exactly 2 accesses, `issued_count`=2.
